// File: rtl/instr_fetch_pkg.sv
// Shared RISC-V fetch definitions: data width, the NOP encoding, FSM states
// and the next-PC select used by the PC register.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INC    = 2'd1,
    PC_TARGET = 2'd2
  } pc_sel_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read bus: fetch unit is master, memory is slave.
interface instr_fetch_if;
  import riscv_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/instr_fetch_pc_reg.sv
// Program-counter register with hold / +4 / target next-PC mux.
module pc_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  pc_sel_t         sel,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc_q
);

  // Update the PC according to the selected next-PC source; +4 wraps mod 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      case (sel)
        PC_INC:    pc_q <= pc_q + 32'd4;
        PC_TARGET: pc_q <= target;
        default:   pc_q <= pc_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding-request instruction fetch unit. Fetches one word at a
// time, holds it for decode until consumed, then moves to PC+4 or a branch
// target. A misaligned target parks the unit in ERR until reset.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_fetch_if.master        imem,
  input  logic                 stall,
  input  logic                 PCSrc,
  input  logic [31:0]          PCTarget,
  output logic                 instr_valid,
  output logic [31:0]          Instr,
  output logic [31:0]          PC,
  output logic [31:0]          PCPlus4,
  output logic                 fetch_err
);

  riscv_pkg::fetch_state_t state_q;
  riscv_pkg::pc_sel_t      pc_sel;
  logic [31:0]             pc_q;
  logic [31:0]             instr_q;
  logic                    fetch_err_q;
  logic                    consume;
  logic                    target_misaligned;

  assign consume           = (state_q == riscv_pkg::HOLD) && !stall;
  assign target_misaligned = (PCTarget[1:0] != 2'b00);

  // Choose the next PC only when decode takes the held instruction.
  always_comb begin
    pc_sel = riscv_pkg::PC_HOLD;
    if (consume) begin
      if (!PCSrc)                 pc_sel = riscv_pkg::PC_INC;
      else if (!target_misaligned) pc_sel = riscv_pkg::PC_TARGET;
      else                        pc_sel = riscv_pkg::PC_HOLD;
    end
  end

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .sel    (pc_sel),
    .target (PCTarget),
    .pc_q   (pc_q)
  );

  // Fetch sequencing: request, capture on rvalid, hold until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= riscv_pkg::IDLE;
      instr_q     <= NOP_INSTR;
      fetch_err_q <= 1'b0;
    end else begin
      case (state_q)
        riscv_pkg::IDLE: begin
          state_q <= riscv_pkg::REQ;
        end
        riscv_pkg::REQ: begin
          if (imem.imem_rvalid) begin
            instr_q <= imem.imem_rdata;
            state_q <= riscv_pkg::HOLD;
          end
        end
        riscv_pkg::HOLD: begin
          if (!stall) begin
            instr_q <= NOP_INSTR;
            if (PCSrc && target_misaligned) begin
              fetch_err_q <= 1'b1;
              state_q     <= riscv_pkg::ERR;
            end else begin
              state_q <= riscv_pkg::REQ;
            end
          end
        end
        default: begin
          state_q <= riscv_pkg::ERR;
        end
      endcase
    end
  end

  // Outputs decode from registered state only; rdata never reaches Instr
  // without passing through instr_q.
  assign imem.imem_req  = (state_q == riscv_pkg::REQ);
  assign imem.imem_addr = pc_q;
  assign instr_valid    = (state_q == riscv_pkg::HOLD);
  assign Instr          = instr_valid ? instr_q : NOP_INSTR;
  assign PC             = pc_q;
  assign PCPlus4        = pc_q + 32'd4;
  assign fetch_err      = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with a memory responder and a
// scoreboard of expected (PC, instruction) pairs.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        instr_valid;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        fetch_err;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (bus.master),
    .stall       (stall),
    .PCSrc       (PCSrc),
    .PCTarget    (PCTarget),
    .instr_valid (instr_valid),
    .Instr       (Instr),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for a request, answer after lat cycles, then check the held output.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int lat);
    int   n;
    exp_t e;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", 32'(bus.imem_req), 32'd1);
    check("imem_addr", bus.imem_addr, addr);
    check("req_no_valid", 32'(instr_valid), 32'd0);
    repeat (lat) tick();
    check("req_held", 32'(bus.imem_req), 32'd1);
    check("addr_stable", bus.imem_addr, addr);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = data;
    sb.push_back('{pc: addr, instr: data});
    tick();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom;
    check("instr_valid", 32'(instr_valid), 32'd1);
    check("req_dropped", 32'(bus.imem_req), 32'd0);
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("Instr", Instr, e.instr);
      check("PC", PC, e.pc);
      check("PCPlus4", PCPlus4, e.pc + 32'd4);
    end
  endtask

  task automatic consume(input logic src, input logic [31:0] tgt);
    stall    = 1'b0;
    PCSrc    = src;
    PCTarget = tgt;
    tick();
    PCSrc    = 1'b0;
    PCTarget = 32'h0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"}, 32'(bus.imem_req), 32'd0);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_instr"}, Instr, NOP);
    check({tag, "_pc"}, PC, 32'h0);
    check({tag, "_pc4"}, PCPlus4, 32'h4);
    check({tag, "_err"}, 32'(fetch_err), 32'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    stall           = 1'b0;
    PCSrc           = 1'b0;
    PCTarget        = 32'h0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;

    // Reset state
    tick();
    tick();
    check_reset_vals("rst");
    rst_n = 1'b1;
    check("idle_no_req", 32'(bus.imem_req), 32'd0);

    // First fetch, then sequential consumes 0,4,8,C
    fetch(32'h0, 32'h0000_2083, 1);
    consume(1'b0, 32'h0);
    fetch(32'h4, 32'h0010_0093, 1);
    consume(1'b0, 32'h0);
    fetch(32'h8, 32'h0020_0113, 2);
    consume(1'b0, 32'h0);
    fetch(32'hC, 32'h0030_0193, 1);

    // Stall in HOLD with PCSrc asserted: everything frozen
    stall    = 1'b1;
    PCSrc    = 1'b1;
    PCTarget = 32'h0000_0080;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_req", 32'(bus.imem_req), 32'd0);
      check("stall_instr", Instr, 32'h0030_0193);
      check("stall_pc", PC, 32'hC);
      check("stall_pc4", PCPlus4, 32'h10);
    end
    consume(1'b0, 32'h0);

    // Stall during REQ has no effect on the request
    stall = 1'b1;
    fetch(32'h10, 32'h0040_0213, 2);

    // Jump to top of address space; +4 wraps to zero
    consume(1'b1, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h0050_0293, 1);
    consume(1'b0, 32'h0);
    fetch(32'h0, 32'h0060_0313, 1);

    // Aligned branch target
    consume(1'b1, 32'h0000_0040);
    fetch(32'h40, 32'h0070_0393, 1);

    // Misaligned branch target -> terminal ERR
    consume(1'b1, 32'h0000_0042);
    for (int i = 0; i < 3; i++) begin
      check("err_flag", 32'(fetch_err), 32'd1);
      check("err_req", 32'(bus.imem_req), 32'd0);
      check("err_valid", 32'(instr_valid), 32'd0);
      check("err_instr", Instr, NOP);
      check("err_pc", PC, 32'h40);
      bus.imem_rvalid = (i == 0);
      bus.imem_rdata  = 32'hDEAD_BEEF;
      tick();
    end
    bus.imem_rvalid = 1'b0;

    // Reset out of ERR, then reset again mid-request
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_err");
    tick();
    rst_n = 1'b1;
    tick();
    check("rq_req", 32'(bus.imem_req), 32'd1);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    tick();
    rst_n           = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBAD0_0BAD;
    tick();
    bus.imem_rvalid = 1'b0;
    check("post_rst_req", 32'(bus.imem_req), 32'd1);
    check("post_rst_valid", 32'(instr_valid), 32'd0);
    check("post_rst_instr", Instr, NOP);
    fetch(32'h0, 32'h0080_0413, 3);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), value driven on Instr when no instruction is valid.
REQ-003 Single clock and asynchronous active-low reset: port clk is the clock, port rst_n is the reset (asserted low, asynchronous assertion).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 imem_req  out  1  instruction-memory read request, held until imem_rvalid.
REQ-007 imem_addr  out  32  word-aligned fetch address, stable while imem_req=1.
REQ-008 imem_rvalid  in  1  read data valid, one-cycle pulse, never earlier than the cycle after imem_req rises.
REQ-009 imem_rdata  in  32  instruction word, sampled when imem_rvalid=1.
REQ-010 stall  in  1  downstream decode/execute not ready; holds the current instruction.
REQ-011 PCSrc  in  1  take branch/jump target; sampled only at consume.
REQ-012 PCTarget  in  32  branch/jump target address.
REQ-013 instr_valid  out  1  Instr/PC/PCPlus4 valid for decode (Instr[6:0] feeds opdecoder op).
REQ-014 Instr  out  32  fetched instruction.
REQ-015 PC  out  32  address of Instr.
REQ-016 PCPlus4  out  32  PC+4, modulo 2^32.
REQ-017 fetch_err  out  1  sticky misaligned-target error.

Function
REQ-018 FSM states: IDLE, REQ, HOLD, ERR.
REQ-019 IDLE: single cycle after reset release, imem_req=0, next REQ.
REQ-020 REQ: imem_req=1, imem_addr=pc_q; on imem_rvalid capture imem_rdata into Instr, next HOLD.
REQ-021 HOLD: instr_valid=1; consume occurs in a cycle with instr_valid=1 and stall=0.
REQ-022 On consume with PCSrc=0: pc_q <= pc_q+4 (wraps 32'hFFFF_FFFC -> 0), next REQ.
REQ-023 On consume with PCSrc=1 and PCTarget[1:0]=0: pc_q <= PCTarget, next REQ.
REQ-024 On consume with PCSrc=1 and PCTarget[1:0]!=0: pc_q unchanged, fetch_err <= 1, next ERR.
REQ-025 ERR: terminal until reset; imem_req=0, instr_valid=0, Instr=NOP_INSTR.
REQ-026 stall=1 in HOLD: Instr, PC, PCPlus4, instr_valid held; PCSrc ignored.
REQ-027 stall in REQ has no effect; request stays outstanding until imem_rvalid.
REQ-028 imem_rvalid outside REQ is ignored.
REQ-029 Instr=NOP_INSTR and instr_valid=0 in every state except HOLD.
REQ-030 Latency: instr_valid rises the cycle after imem_rvalid; next imem_req rises the cycle after consume; minimum three cycles per instruction with single-cycle memory.
REQ-031 All outputs registered or decoded from state and registers only; no combinational path from imem_rdata to Instr.

Reset
REQ-032 rst_n low asynchronously forces: state=IDLE, pc_q=RESET_PC, Instr=NOP_INSTR, instr_valid=0, imem_req=0, fetch_err=0.
REQ-033 Reset during an outstanding request abandons it; any imem_rvalid in the first cycle after release is ignored.
REQ-034 PC=RESET_PC, PCPlus4=RESET_PC+4 while in reset.

Structure
REQ-035 Shared package riscv_pkg holds fetch_state_t enum, XLEN=32, NOP_INSTR constant.
REQ-036 One sub-module pc_reg: asynchronous-reset PC register with next-PC mux (hold / +4 / target).
REQ-037 Target size 150-250 RTL lines.

Verification
REQ-038 Reset release, memory returns 32'h0000_2083 after 1 cycle -> imem_addr=0, Instr=32'h0000_2083, PC=0, PCPlus4=4, instr_valid=1.
REQ-039 Three consecutive consumes, PCSrc=0 -> imem_addr sequence 0,4,8,C.
REQ-040 stall=1 for 5 cycles in HOLD with PCSrc=1 -> outputs frozen, no imem_req, PCSrc ignored.
REQ-041 Consume with PCSrc=1, PCTarget=32'h0000_0040 -> next imem_addr=32'h40, PC=32'h40 after fetch.
REQ-042 Consume with PCSrc=1, PCTarget=32'h0000_0042 -> fetch_err=1, ERR, imem_req=0, Instr=32'h0000_0013.
REQ-043 rst_n low mid-request (rvalid 3 cycles late, with one rvalid pulse in the first cycle after release) -> all outputs at reset values, that pulse ignored, refetch from RESET_PC.
